dest_reg_tracker: RTL and testbench
===================================

// Module: dest_reg_tracker
// PURPOSE
//  Consumes the 5-bit destination register chosen by the RegDst mux in EX and carries it through EX/MEM and MEM/WB.
//  From the tracked destinations it produces the ALU operand forwarding selects and the load-use stall request.
//  Sits between the EX-stage RegDst mux, the forwarding muxes and the ID/EX bubble logic.
// PARAMETERS
//  AW     5   register-address width
//  CNT_W  32  stall-counter width (only with STALL_CNT_EN)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  hold_i       in   1   global freeze (memory wait); tracker stages keep their contents
//  ex_flush_i   in   1   kill the current EX instruction (taken branch/jump)
//  ex_valid_i   in   1   EX stage holds a real instruction
//  ex_regwr_i   in   1   EX instruction writes the register file
//  ex_memrd_i   in   1   EX instruction is a load
//  ex_dest_i    in   AW  RegDst mux output (rt or rd)
//  ex_rs_i      in   AW  EX source A register
//  ex_rt_i      in   AW  EX source B register
//  id_rs_i      in   AW  ID source A register
//  id_rt_i      in   AW  ID source B register
//  fwd_a_o      out  2   operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b_o      out  2   operand B select, same encoding
//  stall_o      out  1   load-use stall: freeze PC/IF/ID, bubble into ID/EX
//  mem_dest_o   out  AW  EX/MEM destination
//  wb_dest_o    out  AW  MEM/WB destination (regfile write address)
//  wb_regwr_o   out  1   regfile write enable at WB
//  stall_cnt_o  out  CNT_W  stall-cycle count (STALL_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): both stage entries cleared (valid=0, regwr=0, memrd=0, dest=0).
//   -> fwd_a_o=fwd_b_o=00, mem_dest_o=wb_dest_o=0, wb_regwr_o=0; stall_o=0 while ex_valid_i=0.
//  Stages: each cycle, hold_i=0: MEM/WB <= EX/MEM; EX/MEM <= EX inputs.
//   - ex_flush_i=1 or ex_valid_i=0: EX/MEM captures a bubble instead (valid=0, regwr=0).
//   - hold_i=1: both stages unchanged; ex_flush_i is ignored and upstream must re-present it. hold beats flush.
//  An entry is a forwarding source only if valid & regwr & dest!=0.
//  Forwarding (combinational from registered entries):
//   - A: EX/MEM source & mem_dest==ex_rs -> 10; else MEM/WB source & wb_dest==ex_rs -> 01; else 00.
//   - B: same rule with ex_rt. EX/MEM has priority (newest value).
//   - An EX/MEM load is never a forwarding source. Load-use stall makes this unreachable; checked by assertion.
//  Load-use stall: stall_o = ex_valid & ex_memrd & ex_regwr & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
//   - Combinational, zero latency. The load itself still advances into EX/MEM.
//   - The next cycle sees a bubble in EX and stall_o drops.
//   - stall_o is still computed under hold_i. ex_flush_i=1 forces stall_o=0.
//  Register $0 never forwards and never stalls.
//  WB->ID write-through is handled in the regfile (write first half); no forwarding path for it here.
// CONFIGURATION
//  STALL_CNT_EN defined:
//   - stall_cnt_o increments on every cycle with stall_o=1 & hold_i=0; saturates at all-ones; reset to 0.
//  Not defined: stall_cnt_o is tied to 0 and no counter flops exist.
// STRUCTURE
//  Package mips_pipe_pkg:
//   - fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01}
//   - REG_ZERO constant
//   - dest_entry_t struct {valid, regwr, memrd, dest[AW-1:0]}
//  Sub-module dest_stage_reg: one entry register with async reset, hold and bubble insert. Instantiated twice (EX/MEM, MEM/WB).
// TESTING
//  1 add $3 (dest 3, regwr); next EX rs=3 -> fwd_a_o=10; one cycle later with EX rs=3 -> fwd_a_o=01.
//  2 EX/MEM dest 5 and MEM/WB dest 5, EX rt=5 -> fwd_b_o=10 (priority); dest 0 with rs=0 -> fwd_a_o=00.
//  3 lw dest 7 in EX, id_rt=7 -> stall_o=1 that cycle; next cycle bubble, stall_o=0; then EX rt=7 -> fwd_b_o=01.
//  4 ex_flush_i=1 with dest 4, regwr -> EX/MEM invalid next cycle; EX rs=4 -> fwd_a_o=00; wb_regwr_o stays 0.
//  5 hold_i=1 for 3 cycles with entries in flight -> mem_dest_o, wb_dest_o, fwd_* constant; flush during hold ignored.
//  6 rst_n low mid-stream (async, between edges) -> all outputs 0 immediately; with STALL_CNT_EN, 4 stall cycles -> stall_cnt_o=4.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types for the EX/MEM/WB destination tracking logic: forwarding selects,
// the zero register, and the per-stage destination entry.
package mips_pipe_pkg;

  localparam int DEST_AW = 5;
  localparam logic [DEST_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b01
  } fwd_sel_e;

  typedef struct packed {
    logic               valid;
    logic               regwr;
    logic               memrd;
    logic [DEST_AW-1:0] dest;
  } dest_entry_t;

  // A stage may supply a value only if it really writes a non-zero register.
  function automatic logic is_fwd_src(input dest_entry_t e);
    return e.valid & e.regwr & (e.dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline entry register for a tracked destination.
// Keeps its contents under hold; loads an all-zero bubble when bubble_i is set.
module dest_stage_reg
  import mips_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  dest_entry_t entry_i,
  output dest_entry_t entry_o
);

  dest_entry_t entry_d;
  dest_entry_t entry_q;

  // Hold wins over bubble so a flush raised during a freeze has no effect.
  always_comb begin
    entry_d = entry_q;
    if (!hold_i) begin
      entry_d = bubble_i ? '0 : entry_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks EX destinations through EX/MEM and MEM/WB, producing ALU forwarding selects and
// the load-use stall. Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module dest_reg_tracker
  import mips_pipe_pkg::*;
#(
  parameter int AW    = DEST_AW,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             ex_flush_i,
  input  logic             ex_valid_i,
  input  logic             ex_regwr_i,
  input  logic             ex_memrd_i,
  input  logic [AW-1:0]    ex_dest_i,
  input  logic [AW-1:0]    ex_rs_i,
  input  logic [AW-1:0]    ex_rt_i,
  input  logic [AW-1:0]    id_rs_i,
  input  logic [AW-1:0]    id_rt_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic [AW-1:0]    mem_dest_o,
  output logic [AW-1:0]    wb_dest_o,
  output logic             wb_regwr_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  dest_entry_t ex_entry;
  dest_entry_t mem_q;
  dest_entry_t wb_q;
  logic        mem_src;
  logic        wb_src;
  logic        wb_memrd_unused;
  fwd_sel_e    fwd_a;
  fwd_sel_e    fwd_b;

  assign ex_entry = '{valid: ex_valid_i, regwr: ex_regwr_i, memrd: ex_memrd_i, dest: ex_dest_i};

  dest_stage_reg u_ex_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold_i   (hold_i),
    .bubble_i (ex_flush_i | ~ex_valid_i),
    .entry_i  (ex_entry),
    .entry_o  (mem_q)
  );

  dest_stage_reg u_mem_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold_i   (hold_i),
    .bubble_i (1'b0),
    .entry_i  (mem_q),
    .entry_o  (wb_q)
  );

  // A load in EX/MEM has no data yet; the stall keeps dependants away from it.
  assign mem_src = is_fwd_src(mem_q) & ~mem_q.memrd;
  assign wb_src  = is_fwd_src(wb_q);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_src && (mem_q.dest == ex_rs_i)) begin
      fwd_a = FWD_MEM;
    end else if (wb_src && (wb_q.dest == ex_rs_i)) begin
      fwd_a = FWD_WB;
    end
    if (mem_src && (mem_q.dest == ex_rt_i)) begin
      fwd_b = FWD_MEM;
    end else if (wb_src && (wb_q.dest == ex_rt_i)) begin
      fwd_b = FWD_WB;
    end
  end

  assign fwd_a_o = fwd_a;
  assign fwd_b_o = fwd_b;

  assign stall_o = ex_valid_i & ex_memrd_i & ex_regwr_i & ~ex_flush_i
                 & (ex_dest_i != REG_ZERO)
                 & ((ex_dest_i == id_rs_i) | (ex_dest_i == id_rt_i));

  assign mem_dest_o      = mem_q.dest;
  assign wb_dest_o       = wb_q.dest;
  assign wb_regwr_o      = wb_q.valid & wb_q.regwr;
  assign wb_memrd_unused = wb_q.memrd;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !hold_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  // A valid EX instruction must never depend on a load that is only now in EX/MEM.
  a_no_load_fwd : assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_valid_i && mem_q.valid && mem_q.regwr && mem_q.memrd && (mem_q.dest != REG_ZERO)
      && ((mem_q.dest == ex_rs_i) || (mem_q.dest == ex_rt_i))));

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Scoreboard bench for dest_reg_tracker: directed hazard scenarios, then a randomized
// pipeline-coherent instruction stream checked against a list-of-writers reference model.
module tb_dest_reg_tracker;

  localparam int AW    = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hold_i = 1'b0;
  logic             ex_flush_i = 1'b0;
  logic             ex_valid_i = 1'b0;
  logic             ex_regwr_i = 1'b0;
  logic             ex_memrd_i = 1'b0;
  logic [AW-1:0]    ex_dest_i = '0;
  logic [AW-1:0]    ex_rs_i = '0;
  logic [AW-1:0]    ex_rt_i = '0;
  logic [AW-1:0]    id_rs_i = '0;
  logic [AW-1:0]    id_rt_i = '0;
  logic [1:0]       fwd_a_o;
  logic [1:0]       fwd_b_o;
  logic             stall_o;
  logic [AW-1:0]    mem_dest_o;
  logic [AW-1:0]    wb_dest_o;
  logic             wb_regwr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  dest_reg_tracker #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_i      (hold_i),
    .ex_flush_i  (ex_flush_i),
    .ex_valid_i  (ex_valid_i),
    .ex_regwr_i  (ex_regwr_i),
    .ex_memrd_i  (ex_memrd_i),
    .ex_dest_i   (ex_dest_i),
    .ex_rs_i     (ex_rs_i),
    .ex_rt_i     (ex_rt_i),
    .id_rs_i     (id_rs_i),
    .id_rt_i     (id_rt_i),
    .fwd_a_o     (fwd_a_o),
    .fwd_b_o     (fwd_b_o),
    .stall_o     (stall_o),
    .mem_dest_o  (mem_dest_o),
    .wb_dest_o   (wb_dest_o),
    .wb_regwr_o  (wb_regwr_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       regwr;
    bit       memrd;
    bit [4:0] dest;
    bit [4:0] rs;
    bit [4:0] rt;
  } instr_t;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [4:0]  md;
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] cnt;
  } exp_t;

  // Reference: the two most recent issued writers, newest first, plus a stall tally.
  instr_t      writers[2];
  int unsigned model_cnt;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_txn = 0;

  function automatic instr_t mk(bit v, bit wr, bit rd, int dest, int rs, int rt);
    instr_t r;
    r.v = v; r.regwr = wr; r.memrd = rd;
    r.dest = 5'(dest); r.rs = 5'(rs); r.rt = 5'(rt);
    return r;
  endfunction

  function automatic instr_t bubble();
    return mk(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [1:0] source_for(bit [4:0] src);
    for (int k = 0; k < 2; k++) begin
      if (src != 0 && writers[k].v && writers[k].regwr && writers[k].dest == src) begin
        // a load still in EX/MEM has nothing to give
        if (k == 0 && writers[k].memrd) continue;
        return (k == 0) ? 2'b10 : 2'b01;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit stall_of(instr_t ex, bit [4:0] irs, bit [4:0] irt, bit flush);
    return ex.v && ex.regwr && ex.memrd && !flush && ex.dest != 0 && (ex.dest == irs || ex.dest == irt);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_fwd_a"}, 32'(fwd_a_o), 0);
    check({tag, "_fwd_b"}, 32'(fwd_b_o), 0);
    check({tag, "_stall"}, 32'(stall_o), 0);
    check({tag, "_mem_dest"}, 32'(mem_dest_o), 0);
    check({tag, "_wb_dest"}, 32'(wb_dest_o), 0);
    check({tag, "_wb_regwr"}, 32'(wb_regwr_o), 0);
    check({tag, "_cnt"}, stall_cnt_o, 0);
  endtask

  // One cycle: drive, predict, then (unless resetting) advance the model at the edge.
  task automatic step(instr_t ex, bit [4:0] irs, bit [4:0] irt, bit hold, bit flush, bit do_rst);
    exp_t e;
    bit   st;
    hold_i = hold; ex_flush_i = flush;
    ex_valid_i = ex.v; ex_regwr_i = ex.regwr; ex_memrd_i = ex.memrd;
    ex_dest_i = ex.dest; ex_rs_i = ex.rs; ex_rt_i = ex.rt;
    id_rs_i = irs; id_rt_i = irt;
    st = stall_of(ex, irs, irt, flush);
    e.fa = source_for(ex.rs);
    e.fb = source_for(ex.rt);
    e.st = st;
    e.md = writers[0].dest;
    e.wd = writers[1].dest;
    e.wr = writers[1].v && writers[1].regwr;
    e.cnt = model_cnt;
    sb.push_back(e);
    if (do_rst) begin
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      ex_valid_i = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      writers[0] = bubble(); writers[1] = bubble(); model_cnt = 0;
      rst_n = 1'b1;
    end else begin
      @(posedge clk);
      if (!hold) begin
`ifdef STALL_CNT_EN
        if (st && model_cnt != 32'hFFFF_FFFF) model_cnt++;
`endif
        writers[1] = writers[0];
        writers[0] = (ex.v && !flush) ? ex : bubble();
      end
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_txn++;
      $display("txn %0d: fa=%b fb=%b stall=%b mem_dest=%0d wb_dest=%0d wb_regwr=%b cnt=%0d",
               n_txn, fwd_a_o, fwd_b_o, stall_o, mem_dest_o, wb_dest_o, wb_regwr_o, stall_cnt_o);
      check("fwd_a", 32'(fwd_a_o), 32'(e.fa));
      check("fwd_b", 32'(fwd_b_o), 32'(e.fb));
      check("stall", 32'(stall_o), 32'(e.st));
      check("mem_dest", 32'(mem_dest_o), 32'(e.md));
      check("wb_dest", 32'(wb_dest_o), 32'(e.wd));
      check("wb_regwr", 32'(wb_regwr_o), 32'(e.wr));
      check("stall_cnt", stall_cnt_o, e.cnt);
    end
  end

  instr_t ex_u;
  instr_t id_u;

  function automatic instr_t rand_instr();
    return mk($urandom % 8 != 0, $urandom % 4 != 0, $urandom % 3 == 0,
              $urandom % 8, $urandom % 8, $urandom % 8);
  endfunction

  initial begin
    writers[0] = bubble(); writers[1] = bubble(); model_cnt = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // add $3, then two consumers of $3: EX/MEM then MEM/WB forwarding
    step(mk(1, 1, 0, 3, 1, 2), 0, 0, 0, 0, 0);
    step(mk(1, 0, 0, 0, 3, 0), 0, 0, 0, 0, 0);
    step(mk(1, 0, 0, 0, 3, 0), 0, 0, 0, 0, 0);
    // $5 in both stages: newest wins; $0 never forwards
    step(mk(1, 1, 0, 5, 0, 0), 0, 0, 0, 0, 0);
    step(mk(1, 1, 0, 5, 0, 0), 0, 0, 0, 0, 0);
    step(mk(1, 1, 0, 0, 0, 5), 0, 0, 0, 0, 0);
    step(mk(1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    // lw $7 with dependant in ID: stall, bubble, then MEM/WB forward
    step(mk(1, 1, 1, 7, 1, 2), 0, 7, 0, 0, 0);
    step(bubble(), 0, 7, 0, 0, 0);
    step(mk(1, 0, 0, 0, 0, 7), 0, 0, 0, 0, 0);
    // flushed writer of $4 must not forward or reach WB
    step(mk(1, 1, 0, 4, 0, 0), 0, 0, 0, 1, 0);
    step(mk(1, 0, 0, 0, 4, 0), 0, 0, 0, 0, 0);
    step(mk(1, 0, 0, 0, 4, 0), 0, 0, 0, 0, 0);
    // freeze with entries in flight; flush raised mid-hold is ignored
    step(mk(1, 1, 0, 6, 0, 0), 0, 0, 0, 0, 0);
    step(mk(1, 1, 0, 9, 6, 0), 0, 0, 0, 0, 0);
    step(mk(1, 1, 0, 11, 6, 9), 0, 0, 1, 0, 0);
    step(mk(1, 1, 0, 11, 6, 9), 0, 0, 1, 1, 0);
    step(mk(1, 1, 0, 11, 6, 9), 0, 0, 1, 0, 0);
    step(mk(1, 1, 0, 11, 6, 9), 0, 0, 0, 0, 0);
    // four counted load-use stalls, plus one under hold that must not count
    step(mk(1, 1, 1, 2, 0, 0), 2, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 1, 1, 2 + k, 0, 0), 0, 2 + k, 0, 0, 0);
      step(bubble(), 0, 2 + k, 0, 0, 0);
    end
    step(bubble(), 0, 0, 0, 0, 0);

    ex_u = rand_instr();
    id_u = rand_instr();
    for (int i = 0; i < 700; i++) begin
      bit hold;
      bit flush;
      bit rst;
      bit st;
      hold  = ($urandom % 8 == 0);
      flush = ($urandom % 10 == 0);
      rst   = (i == 350);
      st    = stall_of(ex_u, id_u.rs, id_u.rt, flush);
      step(ex_u, id_u.rs, id_u.rt, hold, flush, rst);
      if (!hold && !rst) begin
        if (st) begin
          ex_u = bubble();
        end else begin
          ex_u = id_u;
          id_u = rand_instr();
        end
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
